// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM encoding, word-length codes and decode for parity_acc.
package parity_pkg;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_PAR = 2'd2} state_t;
    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;
    localparam int LEN_5 = 5;
    localparam int LEN_6 = 6;
    localparam int LEN_7 = 7;
    localparam int LEN_8 = 8;
    function automatic int wls_len(input logic [1:0] wls);
        return wls == WLS_5 ? LEN_5 : wls == WLS_6 ? LEN_6 : wls == WLS_7 ? LEN_7 : LEN_8;
    endfunction
endpackage

// File: rtl/parity_acc_if.sv
// parity_acc_if: frame control, serial bit and status bundle for parity_acc.
interface parity_acc_if #(parameter int DATA_MAX = 8);
    logic                i_start;
    logic [1:0]          i_wls;
    logic                i_pen;
    logic                i_eps;
    logic                i_stick;
    logic                i_bit_valid;
    logic                i_bit;
    logic                i_clr_err;
    logic                o_busy;
    logic                o_par_rdy;
    logic                o_parity;
    logic                o_done;
    logic                o_perr;
    logic                o_perr_sticky;
    logic [DATA_MAX-1:0] o_data;
    modport master (
        output i_start, i_wls, i_pen, i_eps, i_stick, i_bit_valid, i_bit, i_clr_err,
        input  o_busy, o_par_rdy, o_parity, o_done, o_perr, o_perr_sticky, o_data
    );
    modport slave (
        input  i_start, i_wls, i_pen, i_eps, i_stick, i_bit_valid, i_bit, i_clr_err,
        output o_busy, o_par_rdy, o_parity, o_done, o_perr, o_perr_sticky, o_data
    );
endinterface

// File: rtl/parity_bit_sel.sv
// parity_bit_sel: picks stick, even or odd parity from the running XOR.
module parity_bit_sel (
    input  logic i_acc,
    input  logic i_eps,
    input  logic i_stick,
    output logic o_parity
);
    assign o_parity = i_stick ? ~i_eps : (i_eps ? i_acc : ~i_acc);
endmodule

// File: rtl/parity_acc.sv
// parity_acc: serial frame assembler with parity generation and received-parity check.
module parity_acc
    import parity_pkg::*;
#(
    parameter int DATA_MAX = 8,
    parameter int STICK_EN = 1
) (
    input  logic          i_sys_clk,
    input  logic          i_sys_rst_n,
    parity_acc_if.slave   bus
);
    localparam int CW = $clog2(DATA_MAX + 1);
    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       r_len;
    logic [DATA_MAX-1:0] r_shift;
    logic [DATA_MAX-1:0] r_data;
    logic                r_acc;
    logic                r_pen;
    logic                r_eps;
    logic                r_stick;
    logic                r_par_rdy;
    logic                r_parity;
    logic                r_done;
    logic                r_perr;
    logic                r_sticky;
    logic [CW-1:0]       w_len;
    logic [DATA_MAX-1:0] w_shift;
    logic                w_acc;
    logic                w_last;
    logic                w_parity;
    assign w_len   = (wls_len(bus.i_wls) > DATA_MAX) ? CW'(DATA_MAX) : CW'(wls_len(bus.i_wls));
    assign w_acc   = r_acc ^ bus.i_bit;
    // shift register is cleared at start, so OR-ing the new bit in place is enough
    assign w_shift = r_shift | (DATA_MAX'(bus.i_bit) << r_cnt);
    assign w_last  = r_cnt == r_len - CW'(1);
    parity_bit_sel u_sel (
        .i_acc    (w_acc),
        .i_eps    (r_eps),
        .i_stick  (r_stick),
        .o_parity (w_parity)
    );
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_acc     <= 1'b0;
            r_pen     <= 1'b0;
            r_eps     <= 1'b0;
            r_stick   <= 1'b0;
            r_par_rdy <= 1'b0;
            r_parity  <= 1'b0;
            r_done    <= 1'b0;
            r_perr    <= 1'b0;
            r_sticky  <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_perr   <= 1'b0;
            r_sticky <= r_perr | (r_sticky & ~bus.i_clr_err);
            if (bus.i_start) begin
                r_state   <= S_DATA;
                r_cnt     <= '0;
                r_shift   <= '0;
                r_acc     <= 1'b0;
                r_len     <= w_len;
                r_pen     <= bus.i_pen;
                r_eps     <= bus.i_eps;
                r_stick   <= (STICK_EN != 0) & bus.i_stick;
                r_par_rdy <= 1'b0;
                r_parity  <= 1'b0;
            end else if (bus.i_bit_valid && r_state == S_DATA) begin
                r_shift <= w_shift;
                r_acc   <= w_acc;
                r_cnt   <= r_cnt + CW'(1);
                if (w_last && r_pen) begin
                    r_state   <= S_PAR;
                    r_par_rdy <= 1'b1;
                    r_parity  <= w_parity;
                end else if (w_last) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    r_data  <= w_shift;
                end
            end else if (bus.i_bit_valid && r_state == S_PAR) begin
                r_state   <= S_IDLE;
                r_done    <= 1'b1;
                r_perr    <= bus.i_bit ^ r_parity;
                r_data    <= r_shift;
                r_par_rdy <= 1'b0;
                r_parity  <= 1'b0;
            end
        end
    end
    assign bus.o_busy        = r_state != S_IDLE;
    assign bus.o_par_rdy     = r_par_rdy;
    assign bus.o_parity      = r_parity;
    assign bus.o_done        = r_done;
    assign bus.o_perr        = r_perr;
    assign bus.o_perr_sticky = r_sticky;
    assign bus.o_data        = r_data;
endmodule

// File: tb/tb_parity_acc.sv
// tb_parity_acc: randomized frames checked against a word-level parity model.
module tb_parity_acc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic m_sticky = 1'b0;
    logic [7:0] m_data = 8'h00;
    always #5 clk = ~clk;
    parity_acc_if #(.DATA_MAX(8)) b ();
    parity_acc_if #(.DATA_MAX(6)) b2 ();
    parity_acc #(.DATA_MAX(8), .STICK_EN(1)) dut (.i_sys_clk(clk), .i_sys_rst_n(rst_n), .bus(b));
    parity_acc #(.DATA_MAX(6), .STICK_EN(0)) dut2 (.i_sys_clk(clk), .i_sys_rst_n(rst_n), .bus(b2));
    assign b2.i_start     = b.i_start;
    assign b2.i_wls       = b.i_wls;
    assign b2.i_pen       = b.i_pen;
    assign b2.i_eps       = b.i_eps;
    assign b2.i_stick     = b.i_stick;
    assign b2.i_bit_valid = b.i_bit_valid;
    assign b2.i_bit       = b.i_bit;
    assign b2.i_clr_err   = b.i_clr_err;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [1:0] wls, input logic pen, input logic eps, input logic stick,
                             input logic [7:0] data, input logic pbit, input bit noisy, input logic clr);
        int len;
        logic [7:0] dm;
        logic exp_par;
        logic exp_perr;
        len = 5 + int'(wls);
        dm = 8'(int'(data) & ((1 << len) - 1));
        exp_par = stick ? ~eps : (eps ? ^dm : ~^dm);
        b.i_start = 1'b1; b.i_wls = wls; b.i_pen = pen; b.i_eps = eps; b.i_stick = stick;
        tick;
        b.i_start = 1'b0;
        if ({b.o_busy, b.o_done, b.o_par_rdy} !== 3'b100) begin
            bad++; $display("FAIL frame_start busy/done/rdy got %b want 100", {b.o_busy, b.o_done, b.o_par_rdy});
        end
        total++;
        if (noisy) begin
            b.i_wls = 2'($urandom); b.i_pen = 1'($urandom); b.i_eps = 1'($urandom); b.i_stick = 1'($urandom);
        end
        for (int k = 0; k < len; k++) begin
            if (noisy) repeat ($urandom_range(0, 2)) begin
                b.i_bit_valid = 1'b0; b.i_bit = 1'($urandom); tick;
            end
            if (k == len - 1) begin
                if ({b.o_done, b.o_data} !== {1'b0, m_data}) begin
                    bad++; $display("FAIL data_hold got done=%b data=%h want 0 %h", b.o_done, b.o_data, m_data);
                end
                total++;
            end
            b.i_bit_valid = 1'b1; b.i_bit = dm[k];
            tick;
            b.i_bit_valid = 1'b0;
        end
        exp_perr = 1'b0;
        if (pen) begin
            if (noisy) repeat ($urandom_range(0, 2)) tick;
            if ({b.o_busy, b.o_done, b.o_par_rdy, b.o_parity} !== {3'b101, exp_par}) begin
                bad++; $display("FAIL par_gen busy/done/rdy/par got %b want 101%b",
                                {b.o_busy, b.o_done, b.o_par_rdy, b.o_parity}, exp_par);
            end
            total++;
            b.i_bit_valid = 1'b1; b.i_bit = pbit;
            tick;
            b.i_bit_valid = 1'b0;
            exp_perr = pbit ^ exp_par;
        end
        if ({b.o_done, b.o_perr, b.o_busy, b.o_par_rdy, b.o_data} !== {1'b1, exp_perr, 2'b00, dm}) begin
            bad++; $display("FAIL frame_done done/perr/busy/rdy/data got %b %h want 1%b00 %h",
                            {b.o_done, b.o_perr, b.o_busy, b.o_par_rdy}, b.o_data, exp_perr, dm);
        end
        total++;
        m_data = dm;
        b.i_clr_err = clr;
        tick;
        b.i_clr_err = 1'b0;
        m_sticky = exp_perr | (m_sticky & ~clr);
        if ({b.o_done, b.o_perr, b.o_perr_sticky} !== {2'b00, m_sticky}) begin
            bad++; $display("FAIL sticky done/perr/sticky got %b want 00%b", {b.o_done, b.o_perr, b.o_perr_sticky}, m_sticky);
        end
        total++;
    endtask

    task automatic test_reset;
        b.i_start = 1'b0; b.i_wls = 2'b00; b.i_pen = 1'b0; b.i_eps = 1'b0; b.i_stick = 1'b0;
        b.i_bit_valid = 1'b0; b.i_bit = 1'b0; b.i_clr_err = 1'b0;
        tick; tick;
        if ({b.o_busy, b.o_par_rdy, b.o_parity, b.o_done, b.o_perr, b.o_perr_sticky, b.o_data} !== 14'h0) begin
            bad++; $display("FAIL reset_outputs got %h want 0",
                            {b.o_busy, b.o_par_rdy, b.o_parity, b.o_done, b.o_perr, b.o_perr_sticky, b.o_data});
        end
        total++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors;
        run_frame(2'b11, 1'b1, 1'b1, 1'b0, 8'h53, 1'b0, 1'b0, 1'b0);
        run_frame(2'b11, 1'b1, 1'b0, 1'b0, 8'h53, 1'b0, 1'b0, 1'b0);
        b.i_clr_err = 1'b1;
        tick;
        b.i_clr_err = 1'b0;
        m_sticky = 1'b0;
        if (b.o_perr_sticky !== 1'b0) begin
            bad++; $display("FAIL clr_err sticky got %b want 0", b.o_perr_sticky);
        end
        total++;
        run_frame(2'b00, 1'b0, 1'b0, 1'b0, 8'h15, 1'b0, 1'b0, 1'b0);
        run_frame(2'b10, 1'b1, 1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
        run_frame(2'b01, 1'b1, 1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_abort;
        b.i_start = 1'b1; b.i_wls = 2'b11; b.i_pen = 1'b1; b.i_eps = 1'b1; b.i_stick = 1'b0;
        tick;
        b.i_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b.i_bit_valid = 1'b1; b.i_bit = 1'($urandom); tick;
        end
        b.i_bit_valid = 1'b0;
        run_frame(2'b11, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_idle_bits;
        for (int k = 0; k < 4; k++) begin
            b.i_bit_valid = 1'b1; b.i_bit = 1'($urandom); tick;
        end
        b.i_bit_valid = 1'b0;
        if ({b.o_busy, b.o_done, b.o_par_rdy, b.o_data} !== {3'b000, m_data}) begin
            bad++; $display("FAIL idle_bits busy/done/rdy/data got %b %h want 000 %h",
                            {b.o_busy, b.o_done, b.o_par_rdy}, b.o_data, m_data);
        end
        total++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] a;
        logic [7:0] d;
        a = 8'($urandom) & 8'h1F;
        d = 8'($urandom);
        b.i_start = 1'b1; b.i_wls = 2'b00; b.i_pen = 1'b0; b.i_eps = 1'b0; b.i_stick = 1'b0;
        tick;
        b.i_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            b.i_bit_valid = 1'b1; b.i_bit = a[k]; tick;
        end
        b.i_bit_valid = 1'b0;
        if ({b.o_done, b.o_data} !== {1'b1, a}) begin
            bad++; $display("FAIL b2b_first done/data got %b %h want 1 %h", b.o_done, b.o_data, a);
        end
        total++;
        m_data = a;
        b.i_start = 1'b1; b.i_wls = 2'b11; b.i_pen = 1'b1; b.i_eps = 1'b0; b.i_stick = 1'b0;
        tick;
        b.i_start = 1'b0;
        if ({b.o_busy, b.o_done} !== 2'b10) begin
            bad++; $display("FAIL b2b_accept busy/done got %b want 10", {b.o_busy, b.o_done});
        end
        total++;
        for (int k = 0; k < 8; k++) begin
            b.i_bit_valid = 1'b1; b.i_bit = d[k]; tick;
        end
        if ({b.o_par_rdy, b.o_parity} !== {1'b1, ~^d}) begin
            bad++; $display("FAIL b2b_parity rdy/par got %b want 1%b", {b.o_par_rdy, b.o_parity}, ~^d);
        end
        total++;
        b.i_bit = ~^d;
        tick;
        b.i_bit_valid = 1'b0;
        if ({b.o_done, b.o_perr, b.o_data} !== {2'b10, d}) begin
            bad++; $display("FAIL b2b_second done/perr/data got %b %h want 10 %h", {b.o_done, b.o_perr}, b.o_data, d);
        end
        total++;
        m_data = d;
        tick;
    endtask

    task automatic test_sticky_coincident;
        logic [7:0] d;
        d = 8'($urandom);
        run_frame(2'b11, 1'b1, 1'b1, 1'b0, d, ~^d, 1'b0, 1'b1);
        if (m_sticky !== 1'b1) begin
            bad++; $display("FAIL coincident_model sticky got %b want 1", m_sticky);
        end
        total++;
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++)
            run_frame(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
                      1'($urandom), 1'b1, 1'($urandom_range(0, 3) == 0));
    endtask

    task automatic test_clamp;
        logic [7:0] d;
        logic [7:0] dm;
        logic e;
        logic exp;
        int len;
        for (int t = 0; t < 2; t++) begin
            len = (t == 0) ? 6 : 5;
            e = (t == 0);
            d = 8'($urandom);
            dm = 8'(int'(d) & ((1 << len) - 1));
            exp = e ? ^dm : ~^dm;
            b.i_start = 1'b1; b.i_wls = (t == 0) ? 2'b11 : 2'b00; b.i_pen = 1'b1; b.i_eps = e; b.i_stick = 1'b1;
            tick;
            b.i_start = 1'b0;
            for (int k = 0; k < len; k++) begin
                b.i_bit_valid = 1'b1; b.i_bit = dm[k]; tick;
            end
            b.i_bit_valid = 1'b0;
            if ({b2.o_par_rdy, b2.o_parity} !== {1'b1, exp}) begin
                bad++; $display("FAIL clamp_parity rdy/par got %b want 1%b", {b2.o_par_rdy, b2.o_parity}, exp);
            end
            total++;
            b.i_bit_valid = 1'b1; b.i_bit = ~exp;
            tick;
            b.i_bit_valid = 1'b0;
            if ({b2.o_done, b2.o_perr, b2.o_data} !== {2'b11, dm[5:0]}) begin
                bad++; $display("FAIL clamp_done done/perr/data got %b %h want 11 %h", {b2.o_done, b2.o_perr}, b2.o_data, dm[5:0]);
            end
            total++;
        end
        tick;
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        d = 8'($urandom);
        b.i_start = 1'b1; b.i_wls = 2'b11; b.i_pen = 1'b1; b.i_eps = 1'b1; b.i_stick = 1'b0;
        tick;
        b.i_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            b.i_bit_valid = 1'b1; b.i_bit = d[k]; tick;
        end
        b.i_bit_valid = 1'b0;
        if ({b.o_busy, b.o_par_rdy} !== 2'b11) begin
            bad++; $display("FAIL reach_par busy/rdy got %b want 11", {b.o_busy, b.o_par_rdy});
        end
        total++;
        #2 rst_n = 1'b0;
        #1;
        if ({b.o_busy, b.o_par_rdy, b.o_parity, b.o_done, b.o_perr, b.o_perr_sticky, b.o_data} !== 14'h0) begin
            bad++; $display("FAIL async_reset got %h want 0",
                            {b.o_busy, b.o_par_rdy, b.o_parity, b.o_done, b.o_perr, b.o_perr_sticky, b.o_data});
        end
        total++;
        m_sticky = 1'b0;
        m_data = 8'h00;
        b.i_bit_valid = 1'b1; b.i_bit = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick; tick;
        b.i_bit_valid = 1'b0;
        if ({b.o_done, b.o_perr, b.o_busy, b.o_perr_sticky, b.o_data} !== 12'h0) begin
            bad++; $display("FAIL post_reset done/perr/busy/sticky/data got %h want 0",
                            {b.o_done, b.o_perr, b.o_busy, b.o_perr_sticky, b.o_data});
        end
        total++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(2'b11, 1'b1, 1'b0, 1'b0, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_abort;
        test_idle_bits;
        test_back_to_back;
        test_sticky_coincident;
        test_random;
        test_clamp;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
